// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: shared definitions for the single-bus datapath.
//   - bus source encoding used by the bus multiplexer
//   - ALU operation encoding
//   - IR field bit positions
//   - architectural register bundle and its reset value
//   - helpers for the C-field sign extension and the CON condition
package cpu_datapath_pkg;

  localparam int DATA_W    = 32;
  localparam int MAR_W     = 9;
  localparam int REG_IDX_W = 4;
  localparam int REG_CNT   = 16;

  // IR field positions (each field is 4 bits wide, C2 is 2 bits, C is 19 bits)
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int C2_LSB = 19;
  localparam int C_MSB  = 18;

  typedef enum logic [3:0] {
    BUS_NONE   = 4'd0,
    BUS_PC     = 4'd1,
    BUS_ZLO    = 4'd2,
    BUS_ZHI    = 4'd3,
    BUS_MDR    = 4'd4,
    BUS_C      = 4'd5,
    BUS_INPORT = 4'd6,
    BUS_LO     = 4'd7,
    BUS_HI     = 4'd8,
    BUS_REG    = 4'd9,
    BUS_BASE   = 4'd10
  } bus_src_e;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_MUL = 3'd3,
    ALU_DIV = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_INC = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic [8:0]  mar;
    logic        con;
  } dp_regs_t;

  localparam dp_regs_t REGS_RESET = '0;

  // Sign-extend the 19-bit C field of IR to the bus width.
  function automatic logic [31:0] sext_c(input logic [18:0] c);
    return {{13{c[18]}}, c};
  endfunction

  // Branch condition selected by C2, evaluated on the current bus value.
  function automatic logic cond_eval(input logic [1:0] c2, input logic [31:0] bus);
    logic r;
    case (c2)
      2'b00:   r = (bus == 32'h0000_0000);
      2'b01:   r = (bus != 32'h0000_0000);
      2'b10:   r = ~bus[31];
      2'b11:   r = bus[31];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU, A operand from Y, B operand from the bus.
// Ports:
//   op     - operation select (already priority-resolved by the top)
//   a, b   - 32-bit operands
//   result - 64-bit result {Zhigh, Zlow}
module cpu_alu
  import cpu_datapath_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic signed [63:0] a_ext_s;
  logic signed [63:0] b_ext_s;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;

  assign a_ext_s = {{32{a[31]}}, a};
  assign b_ext_s = {{32{b[31]}}, b};
  assign a_s     = a;
  assign b_s     = b;

  // Signed truncating division; zero divisor and the single overflow case are pinned explicitly.
  always_comb begin
    quo_s = 32'h0000_0000;
    rem_s = 32'h0000_0000;
    if (b == 32'h0000_0000) begin
      quo_s = 32'h0000_0000;
      rem_s = 32'h0000_0000;
    end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      // -2^31 / -1 does not fit; keep the wrapped quotient and a zero remainder
      quo_s = 32'h8000_0000;
      rem_s = 32'h0000_0000;
    end else begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
    end
  end

  // Operation result mux.
  always_comb begin
    result = 64'h0;
    case (op)
      ALU_ADD: result = {32'h0000_0000, a + b};
      ALU_SUB: result = {32'h0000_0000, a - b};
      ALU_MUL: result = a_ext_s * b_ext_s;
      ALU_DIV: result = {rem_s, quo_s};
      ALU_AND: result = {32'h0000_0000, a & b};
      ALU_OR:  result = {32'h0000_0000, a | b};
      ALU_INC: result = {32'h0000_0000, b + 32'h0000_0001};
      default: result = 64'h0;
    endcase
  end

endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: 16 x 32 general register file, one read and one write port
// sharing a single index (the datapath never reads and writes different
// registers in one cycle).
// Ports:
//   clk, clr - clock, synchronous active-high reset (clears all registers)
//   idx      - register index
//   we       - write enable, wdata written to R[idx] at the rising edge
//   rdata    - combinational read of R[idx]
module cpu_regfile
  import cpu_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  idx,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] regs_q [REG_CNT];
  logic [31:0] regs_d [REG_CNT];

  // Next-state: write the addressed register when enabled.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[idx] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array state with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = regs_q[idx];

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit processor datapath driven by one-hot
// strobes from an external control unit; it has no sequencing of its own.
// Ports:
//   clk, clr                 - clock, synchronous active-high reset
//   read, write              - RAM read select for MDR input, RAM write strobe
//   PCout..BAout             - bus drive enables (fixed priority)
//   MARIn..CONIn             - register load enables, IncPC increment request
//   Gra, Grb, Grc            - register field select from IR
//   RIn, Rout                - register file write / read
//   add..orSignal            - ALU op selects (fixed priority)
//   in_port_data             - external input device
//   out_port_data, con_out   - Out.Port register and CON flip-flop
//   bus_data                 - current bus value
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int    MEM_WORDS = 512,
  parameter string MEM_INIT  = "ram_init.hex"
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic        IN_Portout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        MARIn,
  input  logic        PCIn,
  input  logic        MDRIn,
  input  logic        IRIn,
  input  logic        YIn,
  input  logic        IncPC,
  input  logic        HiIn,
  input  logic        LoIn,
  input  logic        CIn,
  input  logic        InIn,
  input  logic        OutIn,
  input  logic        ZIn,
  input  logic        CONIn,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        RIn,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        add,
  input  logic        subtract,
  input  logic        multiply,
  input  logic        divide,
  input  logic        andSignal,
  input  logic        orSignal,
  input  logic [31:0] in_port_data,
  output logic [31:0] out_port_data,
  output logic        con_out,
  output logic [31:0] bus_data
);

  dp_regs_t    regs_q;
  dp_regs_t    regs_d;
  bus_src_e    bus_src_s;
  logic [31:0] bus_s;
  alu_op_e     alu_op_s;
  logic [63:0] alu_res_s;
  logic [3:0]  reg_idx_s;
  logic [31:0] reg_rd_s;
  logic [31:0] ram_rd_s;
  logic        z_load_s;
  logic [31:0] mem_q [MEM_WORDS];

  // CIn is reserved and IR[31:27] (opcode) is decoded by the control unit
  logic unused_ok;
  assign unused_ok = ^{CIn, regs_q.ir[31:27]};

  // Register index from the selected IR field.
  always_comb begin
    reg_idx_s = 4'd0;
    if (Gra) begin
      reg_idx_s = regs_q.ir[RA_LSB +: 4];
    end else if (Grb) begin
      reg_idx_s = regs_q.ir[RB_LSB +: 4];
    end else if (Grc) begin
      reg_idx_s = regs_q.ir[RC_LSB +: 4];
    end else begin
      reg_idx_s = 4'd0;
    end
  end

  // Bus source arbitration in fixed priority order.
  always_comb begin
    bus_src_s = BUS_NONE;
    if (PCout) begin
      bus_src_s = BUS_PC;
    end else if (Zlowout) begin
      bus_src_s = BUS_ZLO;
    end else if (Zhighout) begin
      bus_src_s = BUS_ZHI;
    end else if (MDRout) begin
      bus_src_s = BUS_MDR;
    end else if (Cout) begin
      bus_src_s = BUS_C;
    end else if (IN_Portout) begin
      bus_src_s = BUS_INPORT;
    end else if (LOout) begin
      bus_src_s = BUS_LO;
    end else if (HIout) begin
      bus_src_s = BUS_HI;
    end else if (Rout) begin
      bus_src_s = BUS_REG;
    end else if (BAout) begin
      bus_src_s = BUS_BASE;
    end else begin
      bus_src_s = BUS_NONE;
    end
  end

  // Bus value for the selected source.
  always_comb begin
    bus_s = 32'h0000_0000;
    case (bus_src_s)
      BUS_PC:     bus_s = regs_q.pc;
      BUS_ZLO:    bus_s = regs_q.z_lo;
      BUS_ZHI:    bus_s = regs_q.z_hi;
      BUS_MDR:    bus_s = regs_q.mdr;
      BUS_C:      bus_s = sext_c(regs_q.ir[C_MSB:0]);
      BUS_INPORT: bus_s = regs_q.in_port;
      BUS_LO:     bus_s = regs_q.lo;
      BUS_HI:     bus_s = regs_q.hi;
      BUS_REG:    bus_s = reg_rd_s;
      // base-address read treats R0 as constant zero
      BUS_BASE:   bus_s = (reg_idx_s == 4'd0) ? 32'h0000_0000 : reg_rd_s;
      default:    bus_s = 32'h0000_0000;
    endcase
  end

  // ALU op priority; IncPC only counts when no op select is raised.
  always_comb begin
    alu_op_s = ALU_NOP;
    if (add) begin
      alu_op_s = ALU_ADD;
    end else if (subtract) begin
      alu_op_s = ALU_SUB;
    end else if (multiply) begin
      alu_op_s = ALU_MUL;
    end else if (divide) begin
      alu_op_s = ALU_DIV;
    end else if (andSignal) begin
      alu_op_s = ALU_AND;
    end else if (orSignal) begin
      alu_op_s = ALU_OR;
    end else if (IncPC) begin
      alu_op_s = ALU_INC;
    end else begin
      alu_op_s = ALU_NOP;
    end
  end

  // The increment path loads Z on its own so a fetch needs no ZIn strobe
  assign z_load_s = ZIn | (alu_op_s == ALU_INC);

  cpu_alu u_alu (
    .op     (alu_op_s),
    .a      (regs_q.y),
    .b      (bus_s),
    .result (alu_res_s)
  );

  cpu_regfile u_regfile (
    .clk   (clk),
    .clr   (clr),
    .idx   (reg_idx_s),
    .we    (RIn),
    .wdata (bus_s),
    .rdata (reg_rd_s)
  );

  assign ram_rd_s = mem_q[regs_q.mar];

  // Next-state for every architectural register; loads are independent.
  always_comb begin
    regs_d = regs_q;
    if (PCIn)  regs_d.pc = bus_s;       else regs_d.pc = regs_q.pc;
    if (IRIn)  regs_d.ir = bus_s;       else regs_d.ir = regs_q.ir;
    if (YIn)   regs_d.y = bus_s;        else regs_d.y = regs_q.y;
    if (HiIn)  regs_d.hi = bus_s;       else regs_d.hi = regs_q.hi;
    if (LoIn)  regs_d.lo = bus_s;       else regs_d.lo = regs_q.lo;
    if (OutIn) regs_d.out_port = bus_s; else regs_d.out_port = regs_q.out_port;
    if (MARIn) regs_d.mar = bus_s[MAR_W-1:0]; else regs_d.mar = regs_q.mar;
    if (InIn)  regs_d.in_port = in_port_data; else regs_d.in_port = regs_q.in_port;
    if (MDRIn) begin
      if (read) begin
        regs_d.mdr = ram_rd_s;
      end else begin
        regs_d.mdr = bus_s;
      end
    end else begin
      regs_d.mdr = regs_q.mdr;
    end
    if (z_load_s) begin
      {regs_d.z_hi, regs_d.z_lo} = alu_res_s;
    end else begin
      regs_d.z_hi = regs_q.z_hi;
      regs_d.z_lo = regs_q.z_lo;
    end
    if (CONIn) begin
      regs_d.con = cond_eval(regs_q.ir[C2_LSB +: 2], bus_s);
    end else begin
      regs_d.con = regs_q.con;
    end
  end

  // Architectural register state; clr overrides every load.
  always_ff @(posedge clk) begin
    if (clr) begin
      regs_q <= REGS_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  // RAM write port; contents survive clr.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[regs_q.mar] <= regs_q.mdr;
    end else begin
      mem_q[regs_q.mar] <= mem_q[regs_q.mar];
    end
  end

  assign bus_data      = bus_s;
  assign out_port_data = regs_q.out_port;
  assign con_out       = regs_q.con;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed-vector bench for cpu_datapath. Control strobes are
// driven one cycle at a time; register contents are observed by driving them
// onto the bus 1 ns after a rising edge.
module tb_cpu_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, read, write;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
  logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn;
  logic Gra, Grb, Grc, RIn, Rout, BAout;
  logic add, subtract, multiply, divide, andSignal, orSignal;
  logic [31:0] in_port_data;
  logic [31:0] out_port_data;
  logic        con_out;
  logic [31:0] bus_data;

  int n_cmp = 0;
  int n_mis = 0;

  localparam int SRC_PC = 0, SRC_ZLO = 1, SRC_ZHI = 2, SRC_MDR = 3, SRC_C = 4;
  localparam int SRC_LO = 5, SRC_HI = 6, SRC_R = 7, SRC_BA = 8;

  cpu_datapath #(.MEM_WORDS(512), .MEM_INIT("")) dut (
    .clk(clk), .clr(clr), .read(read), .write(write),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Cout(Cout), .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout),
    .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
    .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn),
    .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .Rout(Rout), .BAout(BAout),
    .add(add), .subtract(subtract), .multiply(multiply), .divide(divide),
    .andSignal(andSignal), .orSignal(orSignal),
    .in_port_data(in_port_data), .out_port_data(out_port_data),
    .con_out(con_out), .bus_data(bus_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_ctrl();
    read = 1'b0; write = 1'b0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    Cout = 1'b0; IN_Portout = 1'b0; LOout = 1'b0; HIout = 1'b0;
    MARIn = 1'b0; PCIn = 1'b0; MDRIn = 1'b0; IRIn = 1'b0; YIn = 1'b0;
    IncPC = 1'b0; HiIn = 1'b0; LoIn = 1'b0; CIn = 1'b0; InIn = 1'b0;
    OutIn = 1'b0; ZIn = 1'b0; CONIn = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; RIn = 1'b0; Rout = 1'b0; BAout = 1'b0;
    add = 1'b0; subtract = 1'b0; multiply = 1'b0; divide = 1'b0;
    andSignal = 1'b0; orSignal = 1'b0;
  endtask

  // apply the currently driven strobes for one edge, then drop them
  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  // drive one register onto the bus and compare (Gr* set by the caller for R/BA)
  task automatic peek(input int src, input string tag, input logic [31:0] exp);
    case (src)
      SRC_PC:  PCout = 1'b1;
      SRC_ZLO: Zlowout = 1'b1;
      SRC_ZHI: Zhighout = 1'b1;
      SRC_MDR: MDRout = 1'b1;
      SRC_C:   Cout = 1'b1;
      SRC_LO:  LOout = 1'b1;
      SRC_HI:  HIout = 1'b1;
      SRC_R:   Rout = 1'b1;
      SRC_BA:  BAout = 1'b1;
      default: PCout = 1'b0;
    endcase
    #1;
    check_eq(tag, bus_data, exp);
    clear_ctrl();
  endtask

  task automatic load_inport(input logic [31:0] v);
    in_port_data = v;
    InIn = 1'b1;
    tick();
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] v);
    load_inport(addr);
    IN_Portout = 1'b1; MARIn = 1'b1; tick();
    load_inport(v);
    IN_Portout = 1'b1; MDRIn = 1'b1; tick();
    write = 1'b1; tick();
  endtask

  // ops = {add, subtract, multiply, divide, andSignal, orSignal}
  task automatic alu_run(input logic [31:0] yv, input logic [31:0] bv, input logic [5:0] ops);
    load_inport(yv);
    IN_Portout = 1'b1; YIn = 1'b1; tick();
    load_inport(bv);
    IN_Portout = 1'b1; ZIn = 1'b1;
    {add, subtract, multiply, divide, andSignal, orSignal} = ops;
    tick();
  endtask

  initial begin
    clear_ctrl();
    in_port_data = 32'h0;
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // reset state
    peek(SRC_PC, "rst_pc", 32'h0);
    check_eq("rst_con", {31'h0, con_out}, 32'h0);
    check_eq("rst_outport", out_port_data, 32'h0);
    peek(SRC_ZLO, "rst_zlo", 32'h0);
    peek(SRC_MDR, "rst_mdr", 32'h0);

    // program word, then show clr beats a simultaneous PC load
    poke(32'h0, 32'h2918_0025);
    load_inport(32'h7);
    IN_Portout = 1'b1; PCIn = 1'b1; tick();
    peek(SRC_PC, "pc_loaded", 32'h7);
    clr = 1'b1; IN_Portout = 1'b1; PCIn = 1'b1; tick();
    clr = 1'b0;
    peek(SRC_PC, "clr_over_load", 32'h0);

    // fetch
    PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; tick();
    Zlowout = 1'b1; PCIn = 1'b1; MDRIn = 1'b1; read = 1'b1; tick();
    peek(SRC_PC, "fetch_pc", 32'h1);
    peek(SRC_MDR, "fetch_mdr", 32'h2918_0025);
    MDRout = 1'b1; IRIn = 1'b1; tick();
    peek(SRC_C, "ir_c_field", 32'h0000_0025);

    // andi R2, R3, 0x25 with R3 = 0xFF
    load_inport(32'h0000_00FF);
    IN_Portout = 1'b1; Grb = 1'b1; RIn = 1'b1; tick();
    Grb = 1'b1; Rout = 1'b1; YIn = 1'b1; tick();
    andSignal = 1'b1; Cout = 1'b1; ZIn = 1'b1; tick();
    Zlowout = 1'b1; Gra = 1'b1; RIn = 1'b1; tick();
    Gra = 1'b1; peek(SRC_R, "andi_r2", 32'h0000_0025);
    Grb = 1'b1; peek(SRC_R, "andi_r3", 32'h0000_00FF);
    Grb = 1'b1; peek(SRC_BA, "ba_r3", 32'h0000_00FF);

    // ALU
    alu_run(32'hFFFF_FFFE, 32'h3, 6'b001000);
    peek(SRC_ZHI, "mul_hi", 32'hFFFF_FFFF);
    peek(SRC_ZLO, "mul_lo", 32'hFFFF_FFFA);
    Zhighout = 1'b1; HiIn = 1'b1; tick();
    Zlowout = 1'b1; LoIn = 1'b1; tick();
    peek(SRC_HI, "hi_reg", 32'hFFFF_FFFF);
    peek(SRC_LO, "lo_reg", 32'hFFFF_FFFA);
    alu_run(32'hFFFF_FFFF, 32'h2, 6'b100000);
    peek(SRC_ZLO, "add_wrap_lo", 32'h1);
    peek(SRC_ZHI, "add_wrap_hi", 32'h0);
    alu_run(32'h7, 32'hFFFF_FFFE, 6'b000100);
    peek(SRC_ZLO, "div_quo", 32'hFFFF_FFFD);
    peek(SRC_ZHI, "div_rem", 32'h1);
    alu_run(32'h7, 32'h0, 6'b000100);
    peek(SRC_ZLO, "div0_lo", 32'h0);
    peek(SRC_ZHI, "div0_hi", 32'h0);
    alu_run(32'h5, 32'h7, 6'b010000);
    peek(SRC_ZLO, "sub_lo", 32'hFFFF_FFFE);
    alu_run(32'h3, 32'h4, 6'b101000);
    peek(SRC_ZLO, "op_priority", 32'h7);
    alu_run(32'hF0, 32'h0F, 6'b000001);
    peek(SRC_ZLO, "or_lo", 32'hFF);
    // IncPC with an op select and no ZIn must leave Z alone
    load_inport(32'h9);
    IN_Portout = 1'b1; add = 1'b1; IncPC = 1'b1; tick();
    peek(SRC_ZLO, "incpc_ignored", 32'hFF);
    IN_Portout = 1'b1; IncPC = 1'b1; tick();
    peek(SRC_ZLO, "incpc_alone", 32'hA);

    // sign extension and BAout on R0
    load_inport(32'h0004_0000);
    IN_Portout = 1'b1; IRIn = 1'b1; tick();
    peek(SRC_C, "cout_sext", 32'hFFFC_0000);
    load_inport(32'h5);
    IN_Portout = 1'b1; Grb = 1'b1; RIn = 1'b1; tick();
    Grb = 1'b1; peek(SRC_R, "r0_rout", 32'h5);
    Grb = 1'b1; peek(SRC_BA, "r0_baout", 32'h0);
    Zlowout = 1'b1; peek(SRC_PC, "bus_priority", 32'h1);

    // memory write/read-back
    poke(32'h5, 32'hDEAD_BEEF);
    load_inport(32'h0);
    IN_Portout = 1'b1; MDRIn = 1'b1; tick();
    peek(SRC_MDR, "mdr_cleared", 32'h0);
    read = 1'b1; MDRIn = 1'b1; tick();
    peek(SRC_MDR, "ram5_readback", 32'hDEAD_BEEF);

    // CON conditions
    load_inport(32'h0008_0000);
    IN_Portout = 1'b1; IRIn = 1'b1; tick();
    load_inport(32'h4);
    IN_Portout = 1'b1; CONIn = 1'b1; tick();
    check_eq("con_ne0", {31'h0, con_out}, 32'h1);
    load_inport(32'h0);
    IN_Portout = 1'b1; IRIn = 1'b1; tick();
    load_inport(32'h4);
    IN_Portout = 1'b1; CONIn = 1'b1; tick();
    check_eq("con_eq0", {31'h0, con_out}, 32'h0);
    load_inport(32'h0018_0000);
    IN_Portout = 1'b1; IRIn = 1'b1; tick();
    load_inport(32'h8000_0000);
    IN_Portout = 1'b1; CONIn = 1'b1; tick();
    check_eq("con_neg", {31'h0, con_out}, 32'h1);

    // output port
    load_inport(32'h1234_ABCD);
    IN_Portout = 1'b1; OutIn = 1'b1; tick();
    check_eq("out_port", out_port_data, 32'h1234_ABCD);

    // reset clears registers but not RAM
    clr = 1'b1; tick();
    clr = 1'b0;
    check_eq("clr_con", {31'h0, con_out}, 32'h0);
    check_eq("clr_outport", out_port_data, 32'h0);
    peek(SRC_ZHI, "clr_zhi", 32'h0);
    read = 1'b1; MDRIn = 1'b1; tick();
    peek(SRC_MDR, "ram_kept", 32'h2918_0025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
